// File: rtl/frame_buf_arbiter.sv
// frame_buf_arbiter
//   Shares NUM_BUF whole-frame SDRAM buffers between one frame writer and one
//   frame reader. The writer never lands on the buffer being read or on the
//   newest complete frame. The reader always picks up the newest complete
//   frame. Frames overwritten before being read and frames read more than
//   once are counted in saturating counters.
// Ports
//   clk, rst                   single clock, synchronous active-high reset
//   wr_frame_start/done        writer frame pulses
//   rd_frame_start/done        reader frame pulses
//   wr_active/wr_stall/wr_idx  writer ownership, stall flag and buffer index
//   wr_b_addr/wr_e_addr        writer buffer word address range
//   wr_rst                     1-cycle pulse on each writer allocation
//   rd_active/rd_idx           reader ownership and buffer index
//   rd_b_addr/rd_e_addr        reader buffer word address range
//   rd_rst                     1-cycle pulse on each read start
//   drop_cnt/rpt_cnt           dropped / repeated frame counters
module frame_buf_arbiter #(
  parameter int NUM_BUF     = 3,
  parameter int FRAME_WORDS = 2073600,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 24,
  parameter int IDX_W       = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_frame_start,
  input  logic              wr_frame_done,
  input  logic              rd_frame_start,
  input  logic              rd_frame_done,
  output logic              wr_active,
  output logic              wr_stall,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [ADDR_W-1:0] wr_b_addr,
  output logic [ADDR_W-1:0] wr_e_addr,
  output logic              wr_rst,
  output logic              rd_active,
  output logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_b_addr,
  output logic [ADDR_W-1:0] rd_e_addr,
  output logic              rd_rst,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  rpt_cnt
);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_WAIT   = 2'd1;
  localparam logic [1:0] W_ACTIVE = 2'd2;
  localparam logic       R_IDLE   = 1'b0;
  localparam logic       R_ACTIVE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [ADDR_W-1:0] buf_base(input logic [IDX_W-1:0] idx);
    buf_base = ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(FRAME_WORDS);
  endfunction

  function automatic logic [ADDR_W-1:0] buf_end(input logic [IDX_W-1:0] idx);
    buf_end = buf_base(idx) + ADDR_W'(FRAME_WORDS) - ADDR_W'(1);
  endfunction

  logic [1:0]        wr_state_q, wr_state_d;
  logic              rd_state_q, rd_state_d;
  logic              wr_active_q, wr_active_d;
  logic              wr_stall_q, wr_stall_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0] wr_b_addr_q, wr_b_addr_d;
  logic [ADDR_W-1:0] wr_e_addr_q, wr_e_addr_d;
  logic              wr_rst_q, wr_rst_d;
  logic              rd_active_q, rd_active_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] rd_b_addr_q, rd_b_addr_d;
  logic [ADDR_W-1:0] rd_e_addr_q, rd_e_addr_d;
  logic              rd_rst_q, rd_rst_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic [IDX_W-1:0]  latest_q, latest_d;
  logic              latest_vld_q, latest_vld_d;
  logic              unread_q, unread_d;

  logic              cand_vld;
  logic [IDX_W-1:0]  cand_idx;
  logic              rd_take;
  logic              wr_alloc;

  // Lowest free buffer index from registered state; scanning downward lets the
  // lowest qualifying index be the last one written.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = {IDX_W{1'b0}};
    for (int b = NUM_BUF - 1; b >= 0; b--) begin
      logic ok;
      ok = !(latest_vld_q && (latest_q == IDX_W'(b))) &&
           !(rd_active_q && (rd_idx_q == IDX_W'(b)));
      cand_vld = cand_vld | ok;
      cand_idx = ok ? IDX_W'(b) : cand_idx;
    end
  end

  assign rd_take = (rd_state_q == R_IDLE) && rd_frame_start && latest_vld_q;

  // Next-state logic for reader and writer FSMs and the shared frame state.
  always_comb begin
    wr_state_d   = wr_state_q;
    rd_state_d   = rd_state_q;
    wr_active_d  = wr_active_q;
    wr_stall_d   = 1'b0;
    wr_idx_d     = wr_idx_q;
    wr_b_addr_d  = wr_b_addr_q;
    wr_e_addr_d  = wr_e_addr_q;
    wr_rst_d     = 1'b0;
    rd_active_d  = rd_active_q;
    rd_idx_d     = rd_idx_q;
    rd_b_addr_d  = rd_b_addr_q;
    rd_e_addr_d  = rd_e_addr_q;
    rd_rst_d     = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    rpt_cnt_d    = rpt_cnt_q;
    latest_d     = latest_q;
    latest_vld_d = latest_vld_q;
    unread_d     = unread_q;
    wr_alloc     = 1'b0;

    // Reader first so a simultaneous writer completion can set unread last.
    case (rd_state_q)
      R_IDLE: begin
        if (rd_take) begin
          rd_state_d  = R_ACTIVE;
          rd_active_d = 1'b1;
          rd_idx_d    = latest_q;
          rd_b_addr_d = buf_base(latest_q);
          rd_e_addr_d = buf_end(latest_q);
          rd_rst_d    = 1'b1;
          unread_d    = 1'b0;
          if (!unread_q && (rpt_cnt_q != CNT_MAX)) begin
            rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
          end else begin
            rpt_cnt_d = rpt_cnt_q;
          end
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_ACTIVE: begin
        if (rd_frame_done) begin
          rd_state_d  = R_IDLE;
          rd_active_d = 1'b0;
        end else begin
          rd_state_d = R_ACTIVE;
        end
      end
      default: begin
        rd_state_d  = R_IDLE;
        rd_active_d = 1'b0;
      end
    endcase

    case (wr_state_q)
      W_IDLE: begin
        if (wr_frame_start) begin
          if (cand_vld) begin
            wr_alloc = 1'b1;
          end else begin
            wr_state_d = W_WAIT;
            wr_stall_d = 1'b1;
          end
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_WAIT: begin
        if (cand_vld) begin
          wr_alloc = 1'b1;
        end else begin
          wr_stall_d = 1'b1;
        end
      end
      W_ACTIVE: begin
        if (wr_frame_done) begin
          wr_state_d   = W_IDLE;
          wr_active_d  = 1'b0;
          latest_d     = wr_idx_q;
          latest_vld_d = 1'b1;
          unread_d     = 1'b1;
          // A frame the reader grabs in this same cycle is not superseded unread.
          if (unread_q && !rd_take && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
          end else begin
            drop_cnt_d = drop_cnt_q;
          end
        end else if (wr_frame_start) begin
          wr_rst_d = 1'b1;
        end else begin
          wr_state_d = W_ACTIVE;
        end
      end
      default: begin
        wr_state_d  = W_IDLE;
        wr_active_d = 1'b0;
      end
    endcase

    if (wr_alloc) begin
      wr_state_d  = W_ACTIVE;
      wr_active_d = 1'b1;
      wr_idx_d    = cand_idx;
      wr_b_addr_d = buf_base(cand_idx);
      wr_e_addr_d = buf_end(cand_idx);
      wr_rst_d    = 1'b1;
    end else begin
      wr_idx_d = wr_idx_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q   <= W_IDLE;
      rd_state_q   <= R_IDLE;
      wr_active_q  <= 1'b0;
      wr_stall_q   <= 1'b0;
      wr_idx_q     <= {IDX_W{1'b0}};
      wr_b_addr_q  <= {ADDR_W{1'b0}};
      wr_e_addr_q  <= {ADDR_W{1'b0}};
      wr_rst_q     <= 1'b0;
      rd_active_q  <= 1'b0;
      rd_idx_q     <= {IDX_W{1'b0}};
      rd_b_addr_q  <= {ADDR_W{1'b0}};
      rd_e_addr_q  <= {ADDR_W{1'b0}};
      rd_rst_q     <= 1'b0;
      drop_cnt_q   <= {CNT_W{1'b0}};
      rpt_cnt_q    <= {CNT_W{1'b0}};
      latest_q     <= {IDX_W{1'b0}};
      latest_vld_q <= 1'b0;
      unread_q     <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      wr_active_q  <= wr_active_d;
      wr_stall_q   <= wr_stall_d;
      wr_idx_q     <= wr_idx_d;
      wr_b_addr_q  <= wr_b_addr_d;
      wr_e_addr_q  <= wr_e_addr_d;
      wr_rst_q     <= wr_rst_d;
      rd_active_q  <= rd_active_d;
      rd_idx_q     <= rd_idx_d;
      rd_b_addr_q  <= rd_b_addr_d;
      rd_e_addr_q  <= rd_e_addr_d;
      rd_rst_q     <= rd_rst_d;
      drop_cnt_q   <= drop_cnt_d;
      rpt_cnt_q    <= rpt_cnt_d;
      latest_q     <= latest_d;
      latest_vld_q <= latest_vld_d;
      unread_q     <= unread_d;
    end
  end

  assign wr_active = wr_active_q;
  assign wr_stall  = wr_stall_q;
  assign wr_idx    = wr_idx_q;
  assign wr_b_addr = wr_b_addr_q;
  assign wr_e_addr = wr_e_addr_q;
  assign wr_rst    = wr_rst_q;
  assign rd_active = rd_active_q;
  assign rd_idx    = rd_idx_q;
  assign rd_b_addr = rd_b_addr_q;
  assign rd_e_addr = rd_e_addr_q;
  assign rd_rst    = rd_rst_q;
  assign drop_cnt  = drop_cnt_q;
  assign rpt_cnt   = rpt_cnt_q;

endmodule
